// File: rtl/sdrc_arb_pkg.sv
// rtl/sdrc_arb_pkg.sv - shared widths and FSM state type for the two-port SDRAM arbiter
package sdrc_arb_pkg;

    localparam int ARB_APP_AW = 26;
    localparam int ARB_DW     = 32;
    localparam int ARB_BL     = 9;
    localparam int ARB_TMO_W  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sdrc_arb_rr2.sv
// rtl/sdrc_arb_rr2.sv - two-way round-robin picker holding the last completed grant
module sdrc_arb_rr2 (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_upd,
    input  logic i_upd_grant,
    output logic o_pick
);

    logic r_last_grant;

    // Resetting to 1 lets port 0 win the first contention.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_last_grant <= 1'b1;
        end else if (i_upd) begin
            r_last_grant <= i_upd_grant;
        end
    end

    assign o_pick = (i_req0 && i_req1) ? ~r_last_grant : (i_req1 & ~i_req0);

endmodule

// File: rtl/sdrc_arb2.sv
// rtl/sdrc_arb2.sv - two-port arbiter in front of an SDRAM controller application port
module sdrc_arb2 import sdrc_arb_pkg::*; #(
    parameter int APP_AW = ARB_APP_AW,
    parameter int DW     = ARB_DW,
    parameter int BL     = ARB_BL,
    parameter int TMO_W  = ARB_TMO_W
) (
    input  logic              sdram_clk,
    input  logic              sdram_resetn,
    input  logic              sdr_init_done,
    input  logic              p0_req,
    input  logic [APP_AW-1:0] p0_req_addr,
    input  logic [BL-1:0]     p0_req_len,
    input  logic              p0_req_wr_n,
    output logic              p0_req_ack,
    input  logic [DW-1:0]     p0_wr_data,
    input  logic [DW/8-1:0]   p0_wr_en_n,
    output logic              p0_wr_next_req,
    output logic              p0_rd_valid,
    output logic [DW-1:0]     p0_rd_data,
    output logic              p0_last,
    input  logic              p1_req,
    input  logic [APP_AW-1:0] p1_req_addr,
    input  logic [BL-1:0]     p1_req_len,
    input  logic              p1_req_wr_n,
    output logic              p1_req_ack,
    input  logic [DW-1:0]     p1_wr_data,
    input  logic [DW/8-1:0]   p1_wr_en_n,
    output logic              p1_wr_next_req,
    output logic              p1_rd_valid,
    output logic [DW-1:0]     p1_rd_data,
    output logic              p1_last,
    output logic              app_req,
    output logic [APP_AW-1:0] app_req_addr,
    output logic [BL-1:0]     app_req_len,
    output logic              app_req_wr_n,
    output logic [DW-1:0]     app_wr_data,
    output logic [DW/8-1:0]   app_wr_en_n,
    input  logic              app_req_ack,
    input  logic              app_wr_next_req,
    input  logic              app_rd_valid,
    input  logic [DW-1:0]     app_rd_data,
    input  logic              app_last_rd,
    input  logic              app_last_wr,
    output logic              busy,
    output logic              err_tmo
);

    localparam logic [TMO_W-1:0] WD_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_grant;
    logic [APP_AW-1:0] r_addr;
    logic [BL-1:0]     r_len;
    logic              r_wr_n;
    logic [TMO_W-1:0]  r_wdog;
    logic              r_err_tmo;
    logic              w_pick;
    logic              w_load;
    logic              w_done;
    logic              w_tmo_hit;
    logic              w_in_data;
    logic              w_last;
    logic              w_g0;
    logic              w_g1;

    sdrc_arb_rr2 u_rr (
        .i_clk       (sdram_clk),
        .i_resetn    (sdram_resetn),
        .i_req0      (p0_req),
        .i_req1      (p1_req),
        .i_upd       (w_done),
        .i_upd_grant (r_grant),
        .o_pick      (w_pick)
    );

    assign w_in_data = (r_state == DATA);
    assign w_last    = w_in_data & (r_wr_n ? (app_last_rd & app_rd_valid) : app_last_wr);

    always_ff @(posedge sdram_clk) begin
        if (!sdram_resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done      = 1'b0;
        w_tmo_hit   = 1'b0;
        case (r_state)
            IDLE: begin
                if (sdr_init_done && (p0_req || p1_req)) begin
                    w_load      = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (app_req_ack) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                if (w_last) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_wdog == WD_LAST) begin
                    // The increment at this edge would reach the all-ones limit.
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sdram_clk) begin
        if (!sdram_resetn) begin
            r_grant   <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_wr_n    <= 1'b0;
            r_wdog    <= '0;
            r_err_tmo <= 1'b0;
        end else begin
            if (w_load) begin
                r_grant <= w_pick;
                r_addr  <= w_pick ? p1_req_addr : p0_req_addr;
                r_len   <= w_pick ? p1_req_len  : p0_req_len;
                r_wr_n  <= w_pick ? p1_req_wr_n : p0_req_wr_n;
            end
            if (r_state == ISSUE) begin
                r_wdog <= '0;
            end else if (w_in_data && (r_wdog != '1)) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_tmo_hit) begin
                r_err_tmo <= 1'b1;
            end
        end
    end

    assign w_g0 = w_in_data & ~r_grant;
    assign w_g1 = w_in_data &  r_grant;

    assign app_req      = (r_state == ISSUE);
    assign app_req_addr = r_addr;
    assign app_req_len  = r_len;
    assign app_req_wr_n = r_wr_n;
    assign app_wr_data  = w_in_data ? (r_grant ? p1_wr_data : p0_wr_data) : '0;
    assign app_wr_en_n  = w_in_data ? (r_grant ? p1_wr_en_n : p0_wr_en_n) : '1;

    assign p0_req_ack     = app_req & ~r_grant & app_req_ack;
    assign p1_req_ack     = app_req &  r_grant & app_req_ack;
    assign p0_wr_next_req = w_g0 & app_wr_next_req;
    assign p1_wr_next_req = w_g1 & app_wr_next_req;
    assign p0_rd_valid    = w_g0 & app_rd_valid;
    assign p1_rd_valid    = w_g1 & app_rd_valid;
    assign p0_rd_data     = w_g0 ? app_rd_data : '0;
    assign p1_rd_data     = w_g1 ? app_rd_data : '0;
    assign p0_last        = w_g0 & w_last;
    assign p1_last        = w_g1 & w_last;

    assign busy    = (r_state != IDLE);
    assign err_tmo = r_err_tmo;

endmodule
